// File: rtl/oscill_pkg.sv
// Shared constants and state encodings for the oscilloscope capture path.
// The trigger stage imports the same default widths.
package oscill_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PRE   = 3'd1;
  localparam state_t ST_ARMED = 3'd2;
  localparam state_t ST_POST  = 3'd3;
  localparam state_t ST_READ  = 3'd4;

endpackage

// File: rtl/oscill_cap_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register has no reset so the array maps onto block RAM.
module oscill_cap_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/oscill_capture.sv
// Trigger-qualified frame capture: circular pre-trigger recording, frame
// freeze on trigger, then oldest-first readout over valid/ready.
module oscill_capture
  import oscill_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  input  logic              trig,
  input  logic              force_trig,
  input  logic              arm,
  input  logic [ADDR_W-1:0] pre_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam logic [ADDR_W:0]   LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   rd_cnt;

  logic              wr_en;
  logic              trig_hit;
  logic              rd_en;
  logic              xfer;
  logic [1:0]        pending;
  logic [DATA_W-1:0] ram_q;
  logic              ram_vld;
  logic              ram_last;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic              skid_last;

  assign busy     = (state != ST_IDLE);
  assign wr_en    = sample_vld & ((state == ST_PRE) | (state == ST_ARMED) | (state == ST_POST));
  assign trig_hit = sample_vld & (trig | force_trig);
  assign xfer     = out_valid & out_ready;

  // Entries already owed to the output stage after this cycle's transfer;
  // a new read is issued only if out+skid can still absorb it next cycle.
  assign pending = 2'(out_valid) + 2'(skid_vld) + 2'(ram_vld) - 2'(xfer);
  assign rd_en   = (state == ST_READ) & ~rd_cnt[ADDR_W] & (pending <= 2'd1);

  oscill_cap_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (sample_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // An ADDR_W-bit pre_len can never exceed DEPTH-1, so it is latched as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pre_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      trig_addr <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            pre_q  <= pre_len;
            wr_ptr <= '0;
            cnt    <= '0;
            rd_cnt <= '0;
            state  <= (pre_len == '0) ? ST_ARMED : ST_PRE;
          end
        end
        ST_PRE: begin
          if (sample_vld) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            cnt    <= cnt + CNT_ONE;
            if (cnt + CNT_ONE == {1'b0, pre_q}) state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (sample_vld) wr_ptr <= wr_ptr + PTR_ONE;
          if (trig_hit) begin
            trig_addr <= wr_ptr;
            cnt       <= '0;
            if (pre_q == '1) begin
              rd_ptr <= wr_ptr - pre_q;
              rd_cnt <= '0;
              state  <= ST_READ;
            end else begin
              state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (sample_vld) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            cnt    <= cnt + CNT_ONE;
            // DEPTH-1-pre_q post samples equals ~pre_q in ADDR_W bits
            if (cnt + CNT_ONE == {1'b0, ~pre_q}) begin
              rd_ptr <= trig_addr - pre_q;
              rd_cnt <= '0;
              state  <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            rd_cnt <= rd_cnt + CNT_ONE;
          end
          if (xfer && out_last) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register plus one-entry skid; out_* only move on a transfer or when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_vld   <= 1'b0;
      ram_last  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      ram_vld  <= rd_en;
      ram_last <= rd_en & (rd_cnt == LAST_IDX);
      if (!out_valid || out_ready) begin
        if (skid_vld) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_last  <= skid_last;
          skid_vld  <= ram_vld;
          if (ram_vld) begin
            skid_data <= ram_q;
            skid_last <= ram_last;
          end
        end else if (ram_vld) begin
          out_valid <= 1'b1;
          out_data  <= ram_q;
          out_last  <= ram_last;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (ram_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= ram_q;
        skid_last <= ram_last;
      end
    end
  end

endmodule

// File: tb/tb_oscill_capture.sv
// Directed bench for oscill_capture with a 16-sample frame and ramp stimulus.
module tb_oscill_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = '0;
  logic       sample_vld = 1'b0;
  logic       trig = 1'b0;
  logic       force_trig = 1'b0;
  logic       arm = 1'b0;
  logic [3:0] pre_len = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [3:0] trig_addr;

  int checks = 0;
  int failures = 0;

  oscill_capture #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .trig       (trig),
    .force_trig (force_trig),
    .arm        (arm),
    .pre_len    (pre_len),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    sample_in  = '0;
    sample_vld = 1'b0;
    trig       = 1'b0;
    force_trig = 1'b0;
    arm        = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_out_last"},  32'(out_last),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_trig_addr"}, 32'(trig_addr), 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Sample k of the ramp carries value k. Sparse mode presents a valid sample
  // every other cycle, triggers via force_trig, and pulses arm on sample 14.
  // rst_mode 1 resets 3 samples after the trigger, 2 resets on the first
  // stalled out_valid.
  task automatic capture(input string name, input int pre, input int trig_at,
                         input int early_lo, input int early_hi, input bit sparse,
                         input bit rnd_ready, input int rst_mode,
                         input int exp_first, input int exp_taddr);
    int c, val, got;
    bit vld, stalled;
    logic [7:0] held_d;
    logic held_l;
    step();
    arm = 1'b1;
    pre_len = pre[3:0];
    sample_vld = 1'b0;
    step();
    arm = 1'b0;
    got = 0;
    c = 0;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    while (got < 16 && c < 400) begin
      vld = sparse ? (c % 2 == 0) : 1'b1;
      val = sparse ? c / 2 : c;
      sample_in  = val[7:0];
      sample_vld = vld;
      trig       = !sparse && vld && (val == trig_at || (val >= early_lo && val <= early_hi));
      force_trig = sparse && ((!vld && val == 7) || (vld && val == trig_at));
      arm        = sparse && vld && val == 14;
      out_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : (rst_mode == 2 ? 1'b0 : 1'b1);
      if (rst_mode == 1 && val == trig_at + 3) begin
        apply_reset({name, "_rst_post"});
        return;
      end
      if (rst_mode == 2 && out_valid) begin
        apply_reset({name, "_rst_read"});
        return;
      end
      if (stalled) begin
        chk({name, "_stall_valid"}, 32'(out_valid), 1);
        chk({name, "_stall_data"},  32'(out_data),  32'(held_d));
        chk({name, "_stall_last"},  32'(out_last),  32'(held_l));
      end
      if (out_valid && out_ready) begin
        chk({name, "_data"}, 32'(out_data), 32'(exp_first + got));
        chk({name, "_last"}, 32'(out_last), 32'(got == 15));
        chk({name, "_done_early"}, 32'(done), 0);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        held_d  = out_data;
        held_l  = out_last;
      end
      step();
      c++;
    end
    if (rst_mode != 0) begin
      chk({name, "_reset_point_reached"}, 0, 1);
      idle_inputs();
      return;
    end
    chk({name, "_count"}, 32'(got), 16);
    idle_inputs();
    chk({name, "_done"},      32'(done),      1);
    chk({name, "_busy_fall"}, 32'(busy),      0);
    chk({name, "_trig_addr"}, 32'(trig_addr), 32'(exp_taddr));
    step();
    chk({name, "_done_pulse"}, 32'(done),      0);
    chk({name, "_valid_off"},  32'(out_valid), 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    capture("basic",     4,  20, -1, -2, 1'b0, 1'b0, 0, 16, 4);
    capture("backpress", 4,  20, -1, -2, 1'b0, 1'b1, 0, 16, 4);
    capture("pre_trig",  4,  10,  1,  2, 1'b0, 1'b0, 0,  6, 10);
    capture("pre_zero",  0,   5, -1, -2, 1'b0, 1'b0, 0,  5, 5);
    // 15 is the largest pre_len an ADDR_W=4 port can carry: no POST phase
    capture("pre_max",   15, 30, -1, -2, 1'b0, 1'b0, 0, 15, 14);
    capture("sparse",    3,  12, -1, -2, 1'b1, 1'b0, 0,  9, 12);

    capture("rst_mid",   4,  20, -1, -2, 1'b0, 1'b0, 1, 16, 4);
    capture("rst_rd",    4,  20, -1, -2, 1'b0, 1'b0, 2, 16, 4);
    capture("after_rst", 4,  20, -1, -2, 1'b0, 1'b0, 0, 16, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
